// File: rtl/mouse_pos_ctrl.sv
// mouse_pos_ctrl
//   Assembles 3-byte PS/2 mouse packets, integrates the signed X/Y deltas
//   into a clamped screen-space cursor kept in a shadow register, and copies
//   the shadow to the outputs only on a frame-start strobe. The cursor
//   therefore only moves during vertical blanking and never tears mid-frame.
//
// Optional feature (compile-time macro MOUSE_PKT_TIMEOUT_EN):
//   When defined, a partial packet left idle for TIMEOUT_CYCLES clocks is
//   dropped, the FSM returns to WAIT_B0 and o_pkt_err pulses once. The
//   TIMEOUT_CYCLES parameter exists only in that build. When undefined, the
//   FSM waits indefinitely for the remaining bytes of a packet.
//
// Ports:
//   i_clk               system clock, all logic on posedge
//   i_rst_n             asynchronous active-low reset
//   i_byte_data[7:0]    received PS/2 byte
//   i_byte_valid        one-cycle strobe, i_byte_data valid (always accepted)
//   i_frame_start       one-cycle strobe at start of vertical blanking
//   o_mouse_position_x  committed cursor X, zero-extended from 10 bits
//   o_mouse_position_y  committed cursor Y, zero-extended from 10 bits
//   o_buttons[2:0]      committed {middle, right, left}
//   o_pos_updated       one-cycle pulse when a commit loads the outputs
//   o_pkt_err           one-cycle pulse on a discarded byte or aborted packet
module mouse_pos_ctrl #(
   parameter int X_MAX  = 639,
   parameter int Y_MAX  = 479,
   parameter int X_INIT = 320,
   parameter int Y_INIT = 240
`ifdef MOUSE_PKT_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_byte_data,
   input  logic        i_byte_valid,
   input  logic        i_frame_start,
   output logic [15:0] o_mouse_position_x,
   output logic [15:0] o_mouse_position_y,
   output logic [2:0]  o_buttons,
   output logic        o_pos_updated,
   output logic        o_pkt_err
);

   typedef enum logic [1:0] {
      WAIT_B0,
      WAIT_B1,
      WAIT_B2
   } state_t;

   localparam logic signed [11:0] X_HI = 12'(X_MAX);
   localparam logic signed [11:0] Y_HI = 12'(Y_MAX);

   state_t      r_state;
   logic        r_apply_stb;
   logic        r_pkt_err;
   logic        r_pending;
   logic        r_pos_updated;

   // Header fields of b0 that matter: {Yovf, Xovf, Ysign, Xsign, btn[2:0]}
   logic [6:0]  r_hdr;
   logic [7:0]  r_b1;
   logic [7:0]  r_b2;

   logic [9:0]  r_sx;
   logic [9:0]  r_sy;
   logic [2:0]  r_sbtn;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [2:0]  r_btn;

   logic signed [8:0]  w_dx9;
   logic signed [8:0]  w_dy9;
   logic signed [11:0] w_dx;
   logic signed [11:0] w_dy;
   logic signed [11:0] w_sx_sum;
   logic signed [11:0] w_sy_sum;

   function automatic logic [9:0] clamp_pos(input logic signed [11:0] v,
                                            input logic signed [11:0] hi);
      if (v < 12'sd0)
         clamp_pos = 10'd0;
      else if (v > hi)
         clamp_pos = hi[9:0];
      else
         clamp_pos = v[9:0];
   endfunction

`ifdef MOUSE_PKT_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] r_to_cnt;
`endif

   // ---- Stage 0: packet assembly FSM ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= WAIT_B0;
         r_apply_stb <= 1'b0;
         r_pkt_err   <= 1'b0;
`ifdef MOUSE_PKT_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         r_apply_stb <= 1'b0;
         r_pkt_err   <= 1'b0;
         if (i_byte_valid) begin
            case (r_state)
               WAIT_B0: begin
                  // Bit 3 of a header byte is always set; anything else is
                  // a misaligned byte and is dropped to resynchronise.
                  if (i_byte_data[3])
                     r_state <= WAIT_B1;
                  else
                     r_pkt_err <= 1'b1;
               end
               WAIT_B1: r_state <= WAIT_B2;
               WAIT_B2: begin
                  r_state     <= WAIT_B0;
                  r_apply_stb <= 1'b1;
               end
               default: r_state <= WAIT_B0;
            endcase
         end
`ifdef MOUSE_PKT_TIMEOUT_EN
         if (i_byte_valid || r_state == WAIT_B0) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt  <= '0;
            r_state   <= WAIT_B0;
            r_pkt_err <= 1'b1;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
`endif
      end
   end

   // Packet byte holding registers: pure data, no reset needed.
   always_ff @(posedge i_clk) begin
      if (i_byte_valid) begin
         case (r_state)
            WAIT_B0: if (i_byte_data[3]) r_hdr <= {i_byte_data[7:4], i_byte_data[2:0]};
            WAIT_B1: r_b1 <= i_byte_data;
            WAIT_B2: r_b2 <= i_byte_data;
            default: ;
         endcase
      end
   end

   // ---- Stage 1: delta decode and shadow integration ----
   // An overflow flag makes that axis's delta meaningless, so it is zeroed.
   assign w_dx9    = r_hdr[5] ? 9'sd0 : $signed({r_hdr[3], r_b1});
   assign w_dy9    = r_hdr[6] ? 9'sd0 : $signed({r_hdr[4], r_b2});
   assign w_dx     = {{3{w_dx9[8]}}, w_dx9};
   assign w_dy     = {{3{w_dy9[8]}}, w_dy9};
   assign w_sx_sum = $signed({2'b00, r_sx}) + w_dx;
   // PS/2 Y is up-positive, screen Y is down-positive.
   assign w_sy_sum = $signed({2'b00, r_sy}) - w_dy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sx          <= 10'(X_INIT);
         r_sy          <= 10'(Y_INIT);
         r_sbtn        <= 3'd0;
         r_x           <= 10'(X_INIT);
         r_y           <= 10'(Y_INIT);
         r_btn         <= 3'd0;
         r_pending     <= 1'b0;
         r_pos_updated <= 1'b0;
      end else begin
         r_pos_updated <= 1'b0;
         // ---- Stage 2: frame-synchronous commit ----
         // Commit reads the shadow before this cycle's update lands; if an
         // update coincides, the later assignment keeps pending set so the
         // new value goes out at the next frame.
         if (i_frame_start && r_pending) begin
            r_x           <= r_sx;
            r_y           <= r_sy;
            r_btn         <= r_sbtn;
            r_pos_updated <= 1'b1;
            r_pending     <= 1'b0;
         end
         if (r_apply_stb) begin
            r_sx      <= clamp_pos(w_sx_sum, X_HI);
            r_sy      <= clamp_pos(w_sy_sum, Y_HI);
            r_sbtn    <= r_hdr[2:0];
            r_pending <= 1'b1;
         end
      end
   end

   assign o_mouse_position_x = {6'd0, r_x};
   assign o_mouse_position_y = {6'd0, r_y};
   assign o_buttons          = r_btn;
   assign o_pos_updated      = r_pos_updated;
   assign o_pkt_err          = r_pkt_err;

endmodule
